std_linear_sec_decoder: RTL

STD_LINEAR_SEC_DECODER -- requirements
Module: std_linear_sec_decoder

---
 rtl/std_linear_sec_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/std_linear_sec_decoder.sv
// std_linear_sec_decoder: two-stage single-error-correcting Hamming decoder.
// The codeword is (2^P)-1 bits long. Bit k-1 holds Hamming position k.
// Parity bits sit at the power-of-two positions; data fills the rest in ascending order.
// Stage 1 captures the codeword together with its syndrome.
// Stage 2 applies the correction and presents the data word.
// Both stages use a valid/ready handshake in which bubbles collapse.
// A saturating counter tallies the corrected words that are delivered downstream.
module std_linear_sec_decoder #(
  parameter int P  = 4,
  parameter int K  = (1 << P) - 1,
  parameter int N  = K - P,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [K-1:0]  i_codeword,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_word,
  output logic [P-1:0]  o_syndrome,
  output logic          o_corrected,
  input  logic          i_clear_count,
  output logic [CW-1:0] o_err_count
);

  // Syndrome: XOR of the position indices of all set bits.
  function automatic logic [P-1:0] calc_syndrome(input logic [K-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int k = 1; k <= K; k++) begin
      if (cw[k-1]) s ^= P'(k);
    end
    return s;
  endfunction

  // Flip the bit that a nonzero syndrome points at.
  // Every nonzero syndrome names a real position, because K = 2^P-1.
  function automatic logic [K-1:0] apply_correction(input logic [K-1:0] cw,
                                                    input logic [P-1:0] s);
    logic [K-1:0] c;
    int           idx;
    c = cw;
    if (s != '0) begin
      idx    = int'(s) - 1;
      c[idx] = ~c[idx];
    end
    return c;
  endfunction

  // Gather the non-power-of-two positions into the data word, in ascending order.
  function automatic logic [N-1:0] extract_data(input logic [K-1:0] cw);
    logic [N-1:0] w;
    int           j;
    w = '0;
    j = 0;
    for (int k = 1; k <= K; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (j < N) w[j] = cw[k-1];
        j++;
      end
    end
    return w;
  endfunction

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Stage 1 registers
  logic [K-1:0]  cw_p1_q;
  logic [P-1:0]  syn_p1_q;
  logic          vld_p1_q, vld_p1_d;
  // Stage 2 registers
  logic [N-1:0]  word_p2_q, word_p2_d;
  logic [P-1:0]  syn_p2_q;
  logic          corr_p2_q;
  logic          vld_p2_q, vld_p2_d;
  // Error counter
  logic [CW-1:0] cnt_q, cnt_d;

  logic in_hs, out_hs, s2_load;

  assign out_hs  = vld_p2_q & i_ready;
  assign s2_load = vld_p1_q & (~vld_p2_q | i_ready);
  assign o_ready = ~vld_p1_q | s2_load;
  assign in_hs   = i_valid & o_ready;

  assign o_valid     = vld_p2_q;
  assign o_word      = word_p2_q;
  assign o_syndrome  = syn_p2_q;
  assign o_corrected = corr_p2_q;
  assign o_err_count = cnt_q;

  // Next-state logic for the valid bits, the counter and the corrected data word.
  always_comb begin
    vld_p1_d = vld_p1_q;
    if (in_hs)        vld_p1_d = 1'b1;
    else if (s2_load) vld_p1_d = 1'b0;

    vld_p2_d = vld_p2_q;
    if (s2_load)     vld_p2_d = 1'b1;
    else if (out_hs) vld_p2_d = 1'b0;

    cnt_d = cnt_q;
    if (i_clear_count)                                cnt_d = '0;
    else if (out_hs && corr_p2_q && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

    word_p2_d = extract_data(apply_correction(cw_p1_q, syn_p1_q));
  end

  // Control state: the stage valid bits and the error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stage 0 -> 1: capture the codeword and its syndrome on an input handshake.
  always_ff @(posedge i_clk) begin
    if (in_hs) begin
      cw_p1_q  <= i_codeword;
      syn_p1_q <= calc_syndrome(i_codeword);
    end
  end

  // Stage 1 -> 2: corrected result; cleared by reset because these registers drive the outputs directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_p2_q <= '0;
      syn_p2_q  <= '0;
      corr_p2_q <= 1'b0;
    end else if (s2_load) begin
      word_p2_q <= word_p2_d;
      syn_p2_q  <= syn_p1_q;
      corr_p2_q <= (syn_p1_q != '0);
    end
  end

endmodule
